// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs toward the controller,
// PC/pipeline-register controls and performance counters back to the pipe.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_halt_req;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        mem_busy;
    logic        resume;
    logic        PCWrite;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pipe_hold;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_halt_req,
        input  ex_mem_read, ex_rd, ex_branch_taken, ex_branch_target,
        input  mem_busy, resume,
        output PCWrite, pc_src, branch_target, ifid_write, ifid_flush,
        output idex_flush, pipe_hold, halted,
        output cycle_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_halt_req,
        output ex_mem_read, ex_rd, ex_branch_taken, ex_branch_target,
        output mem_busy, resume,
        input  PCWrite, pc_src, branch_target, ifid_write, ifid_flush,
        input  idex_flush, pipe_hold, halted,
        input  cycle_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard/sequencing controller: mem wait, branch redirect,
// load-use stall, ECALL drain/halt, plus cycle/stall/flush counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.master hz
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  drain, drain_nx;
    logic [31:0] cyc, stl, flc;
    logic        lu, stall_inc, flush_inc;

    always_comb begin
        lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
             ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
              (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
    end

    assign hz.branch_target = hz.ex_branch_target;
    assign hz.cycle_cnt     = cyc;
    assign hz.stall_cnt     = stl;
    assign hz.flush_cnt     = flc;

    always_comb begin
        state_nx      = state;
        drain_nx      = drain;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        hz.PCWrite    = 1'b0;
        hz.pc_src     = 1'b0;
        hz.ifid_write = 1'b0;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.pipe_hold  = 1'b0;
        hz.halted     = 1'b0;
        if (rst) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    priority case (1'b1)
                        hz.mem_busy: begin
                            hz.pipe_hold = 1'b1;
                            stall_inc    = 1'b1;
                        end
                        hz.ex_branch_taken: begin
                            hz.pc_src     = 1'b1;
                            hz.PCWrite    = 1'b1;
                            hz.ifid_write = 1'b1;
                            hz.ifid_flush = 1'b1;
                            hz.idex_flush = 1'b1;
                            flush_inc     = 1'b1;
                        end
                        lu: begin
                            hz.idex_flush = 1'b1;
                            stall_inc     = 1'b1;
                        end
                        hz.id_halt_req: begin
                            // halt instr moves on to EX; fetch stays frozen
                            hz.ifid_write = 1'b1;
                            hz.ifid_flush = 1'b1;
                            drain_nx      = DRAIN_LOAD;
                            state_nx      = DRAIN;
                        end
                        default: begin
                            hz.PCWrite    = 1'b1;
                            hz.ifid_write = 1'b1;
                        end
                    endcase
                end
                DRAIN: begin
                    hz.ifid_write = 1'b1;
                    hz.ifid_flush = 1'b1;
                    if (hz.mem_busy) begin
                        hz.pipe_hold = 1'b1;
                        stall_inc    = 1'b1;
                    end else begin
                        drain_nx = drain - 4'd1;
                        if (drain <= 4'd1) begin
                            drain_nx = 4'd0;
                            state_nx = HALTED;
                        end
                    end
                end
                HALTED: begin
                    hz.halted    = 1'b1;
                    hz.pipe_hold = 1'b1;
                    if (hz.resume) begin
                        state_nx = RUN;
                    end
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            drain <= 4'd0;
            cyc   <= 32'd0;
            stl   <= 32'd0;
            flc   <= 32'd0;
        end else begin
            state <= state_nx;
            drain <= drain_nx;
            cyc   <= cyc + 32'(state != HALTED);
            stl   <= stl + 32'(stall_inc);
            flc   <= flc + 32'(flush_inc);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch flush, drain with
// memory wait, halt/resume and reset mid-drain.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_cyc;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
    bit   [4:0]  pat;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs1           = 5'd0;
        hz.id_rs2           = 5'd0;
        hz.id_uses_rs1      = 1'b0;
        hz.id_uses_rs2      = 1'b0;
        hz.id_halt_req      = 1'b0;
        hz.ex_mem_read      = 1'b0;
        hz.ex_rd            = 5'd0;
        hz.ex_branch_taken  = 1'b0;
        hz.ex_branch_target = 32'h0000_0040;
        hz.mem_busy         = 1'b0;
        hz.resume           = 1'b0;
    endtask

    task automatic tick(input bit counts);
        @(posedge clk);
        #1;
        if (counts) exp_cyc++;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cyc   = 0;
        exp_stall = 0;
        exp_flush = 0;
        idle();
        rst = 1'b1;
        #1;
        chk("rst_pcwrite", hz.PCWrite, 0);
        chk("rst_ifid_write", hz.ifid_write, 0);
        chk("rst_ifid_flush", hz.ifid_flush, 1);
        chk("rst_idex_flush", hz.idex_flush, 1);
        chk("rst_hold", hz.pipe_hold, 0);
        chk("rst_halted", hz.halted, 0);
        tick(0);
        tick(0);
        chk("rst_cycle", hz.cycle_cnt, 0);
        chk("rst_stall", hz.stall_cnt, 0);
        chk("rst_flush", hz.flush_cnt, 0);
        rst = 1'b0;
        #1;
        chk("run_pcwrite", hz.PCWrite, 1);
        chk("run_ifid_write", hz.ifid_write, 1);
        chk("run_ifid_flush", hz.ifid_flush, 0);

        // lw x5 in EX, ID reads rs2=x5
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd5;
        hz.id_rs2      = 5'd5;
        hz.id_uses_rs2 = 1'b1;
        hz.id_rs1      = 5'd7;
        hz.id_uses_rs1 = 1'b1;
        #1;
        chk("lu_pcwrite", hz.PCWrite, 0);
        chk("lu_ifid_write", hz.ifid_write, 0);
        chk("lu_idex_flush", hz.idex_flush, 1);
        chk("lu_ifid_flush", hz.ifid_flush, 0);
        tick(1);
        exp_stall++;
        idle();
        #1;
        chk("lu_stall_cnt", hz.stall_cnt, exp_stall);
        chk("lu_after_pcwrite", hz.PCWrite, 1);
        chk("lu_cycle_cnt", hz.cycle_cnt, exp_cyc);

        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd0;
        hz.id_rs2      = 5'd0;
        hz.id_uses_rs2 = 1'b1;
        #1;
        chk("rd0_pcwrite", hz.PCWrite, 1);
        hz.ex_rd       = 5'd5;
        hz.id_rs2      = 5'd5;
        hz.id_uses_rs2 = 1'b0;
        #1;
        chk("nouse_pcwrite", hz.PCWrite, 1);
        chk("nouse_idex_flush", hz.idex_flush, 0);
        hz.id_rs1      = 5'd5;
        hz.id_uses_rs1 = 1'b1;
        #1;
        chk("rs1_lu_pcwrite", hz.PCWrite, 0);
        idle();
        #1;
        tick(1);

        // taken branch wins over load-use and halt
        hz.ex_mem_read      = 1'b1;
        hz.ex_rd            = 5'd5;
        hz.id_rs2           = 5'd5;
        hz.id_uses_rs2      = 1'b1;
        hz.id_halt_req      = 1'b1;
        hz.ex_branch_taken  = 1'b1;
        hz.ex_branch_target = 32'h0000_0100;
        #1;
        chk("br_pc_src", hz.pc_src, 1);
        chk("br_target", hz.branch_target, 32'h0000_0100);
        chk("br_ifid_flush", hz.ifid_flush, 1);
        chk("br_idex_flush", hz.idex_flush, 1);
        chk("br_pcwrite", hz.PCWrite, 1);
        chk("br_ifid_write", hz.ifid_write, 1);
        tick(1);
        exp_flush++;
        idle();
        #1;
        chk("br_flush_cnt", hz.flush_cnt, exp_flush);
        chk("br_stall_cnt", hz.stall_cnt, exp_stall);
        chk("br_run_pcwrite", hz.PCWrite, 1);
        chk("br_pc_src_off", hz.pc_src, 0);

        hz.mem_busy = 1'b1;
        #1;
        chk("busy_hold", hz.pipe_hold, 1);
        chk("busy_pcwrite", hz.PCWrite, 0);
        chk("busy_ifid_write", hz.ifid_write, 0);
        tick(1);
        exp_stall++;
        idle();
        #1;
        chk("busy_stall_cnt", hz.stall_cnt, exp_stall);

        // halt accept, then drain with two busy cycles
        hz.id_halt_req = 1'b1;
        #1;
        chk("halt_pcwrite", hz.PCWrite, 0);
        chk("halt_ifid_write", hz.ifid_write, 1);
        chk("halt_ifid_flush", hz.ifid_flush, 1);
        chk("halt_idex_flush", hz.idex_flush, 0);
        tick(1);
        pat = 5'b00110;
        for (int i = 0; i < 5; i++) begin
            idle();
            hz.mem_busy        = pat[i];
            hz.ex_branch_taken = 1'b1;
            hz.id_halt_req     = 1'b1;
            hz.resume          = (i == 4);
            #1;
            chk("drain_pcwrite", hz.PCWrite, 0);
            chk("drain_pc_src", hz.pc_src, 0);
            chk("drain_hold", hz.pipe_hold, 32'(pat[i]));
            chk("drain_halted", hz.halted, 0);
            chk("drain_ifid_flush", hz.ifid_flush, 1);
            tick(1);
            if (pat[i]) exp_stall++;
        end
        idle();
        #1;
        chk("halted_rise", hz.halted, 1);
        chk("drain_stall_cnt", hz.stall_cnt, exp_stall);
        chk("drain_cycle_cnt", hz.cycle_cnt, exp_cyc);

        for (int i = 0; i < 10; i++) begin
            hz.mem_busy        = 1'($urandom);
            hz.ex_branch_taken = 1'($urandom);
            hz.id_halt_req     = 1'($urandom);
            #1;
            chk("hlt_halted", hz.halted, 1);
            chk("hlt_hold", hz.pipe_hold, 1);
            chk("hlt_pcwrite", hz.PCWrite, 0);
            chk("hlt_ifid_write", hz.ifid_write, 0);
            tick(0);
        end
        idle();
        #1;
        chk("hlt_cycle_frozen", hz.cycle_cnt, exp_cyc);
        chk("hlt_stall_frozen", hz.stall_cnt, exp_stall);
        hz.resume = 1'b1;
        #1;
        chk("resume_still_halted", hz.halted, 1);
        tick(0);
        hz.resume = 1'b0;
        #1;
        chk("resume_halted", hz.halted, 0);
        chk("resume_pcwrite", hz.PCWrite, 1);
        chk("resume_hold", hz.pipe_hold, 0);
        tick(1);
        #1;
        chk("resume_cycle_cnt", hz.cycle_cnt, exp_cyc);

        // reset in the middle of a drain
        hz.id_halt_req = 1'b1;
        #1;
        tick(1);
        idle();
        tick(1);
        rst = 1'b1;
        #1;
        chk("rst2_pcwrite", hz.PCWrite, 0);
        chk("rst2_ifid_flush", hz.ifid_flush, 1);
        tick(0);
        rst     = 1'b0;
        exp_cyc = 0;
        #1;
        chk("rst2_halted", hz.halted, 0);
        chk("rst2_pcwrite_run", hz.PCWrite, 1);
        chk("rst2_cycle", hz.cycle_cnt, 0);
        chk("rst2_stall", hz.stall_cnt, 0);
        chk("rst2_flush", hz.flush_cnt, 0);
        for (int i = 0; i < 4; i++) tick(1);
        chk("rst2_no_halt", hz.halted, 0);
        chk("rst2_cycle_run", hz.cycle_cnt, exp_cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
